npu_in_loader: RTL and testbench

- Read-side counterpart to the NPU output writer. Fetches a block of operand words from the on-chip SRAM and streams them into the NPU input buffer.
- The output path shifts results out and asserts a memory write-enable; this block issues read addresses and captures read data, which the SRAM returns one cycle after the request. It then presents the data to the input buffer with a valid/ready handshake.
- The word count is the same {DB,DD} product-count value that loads the accumulation down counter. The block pulses done once the whole block has been delivered, which lets the accumulation FSM start.

---
 rtl/npu_pkg.sv | 15 +
 rtl/npu_in_loader_if.sv | 24 ++
 rtl/npu_skid_fifo.sv | 49 ++++
 rtl/npu_in_loader.sv | 126 ++++++++++++
 tb/tb_npu_in_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths and the input-loader state encoding.
package npu_pkg;

    localparam int NPU_ADDR_W = 16;
    localparam int NPU_DATA_W = 8;
    localparam int NPU_CNT_W  = 16;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_RUN   = 2'd1,
        LDR_DRAIN = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/npu_in_loader_if.sv
// SRAM read port plus input-buffer stream between the input loader (master) and its peers (slave).
interface npu_in_loader_if
    import npu_pkg::*;
#(
    parameter int ADDR_W = NPU_ADDR_W,
    parameter int DATA_W = NPU_DATA_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              buf_ready;

    modport master (
        output rd_en, rd_addr, buf_valid, buf_data,
        input  rd_data, buf_ready
    );

    modport slave (
        input  rd_en, rd_addr, buf_valid, buf_data,
        output rd_data, buf_ready
    );
endinterface

// File: rtl/npu_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; the head word is visible on pop_data while not empty.
module npu_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [1:0]        count,
    output logic              empty,
    output logic              full
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        empty   = (count == 2'd0);
        full    = (count == 2'd2);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/npu_in_loader.sv
// Fetches len words from SRAM starting at base_addr and streams them to the NPU input buffer.
module npu_in_loader
    import npu_pkg::*;
#(
    parameter int ADDR_W = NPU_ADDR_W,
    parameter int DATA_W = NPU_DATA_W,
    parameter int CNT_W  = NPU_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  len,
    npu_in_loader_if.master   bus,
    output logic              busy,
    output logic              done
);
    ldr_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remaining;
    logic              inflight;
    logic              busy_q;
    logic              done_q;

    logic              rd_go;
    logic              push;
    logic              pop;
    logic [1:0]        level_next;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic              valid_c;
    logic [DATA_W-1:0] data_c;

    npu_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.rd_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A returning word bypasses the FIFO when it is empty and the buffer is ready;
    // otherwise it is captured, independent of enable.
    always_comb begin
        rd_go      = (state == LDR_RUN) && enable && (remaining != '0)
                     && ((fifo_count + 2'(inflight)) < 2'd2);
        valid_c    = !fifo_empty || inflight;
        data_c     = '0;
        if (valid_c) begin
            data_c = fifo_empty ? bus.rd_data : fifo_head;
        end
        pop        = bus.buf_ready && !fifo_empty;
        push       = inflight && !(fifo_empty && bus.buf_ready);
        level_next = fifo_count + 2'(push) - 2'(pop);
    end

    assign bus.rd_en     = rd_go;
    assign bus.rd_addr   = addr_q;
    assign bus.buf_valid = valid_c;
    assign bus.buf_data  = data_c;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LDR_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            inflight <= rd_go;
            if (rd_go) begin
                addr_q    <= addr_q + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
            case (state)
                LDR_IDLE: begin
                    if (start && enable) begin
                        addr_q    <= base_addr;
                        remaining <= len;
                        busy_q    <= 1'b1;
                        if (len == '0) begin
                            state  <= LDR_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= LDR_RUN;
                        end
                    end
                end
                LDR_RUN: begin
                    if (rd_go && (remaining == CNT_W'(1))) begin
                        state <= LDR_DRAIN;
                    end
                end
                LDR_DRAIN: begin
                    // Leave on the edge that hands over the last word, not one cycle later.
                    if (enable && (level_next == 2'd0)) begin
                        state  <= LDR_DONE;
                        done_q <= 1'b1;
                    end
                end
                LDR_DONE: begin
                    if (enable) begin
                        state  <= LDR_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_full && push && !pop));

endmodule

// File: tb/tb_npu_in_loader.sv
// Scoreboard bench for npu_in_loader: stimulus queues expected addresses, words and done timing.
module tb_npu_in_loader;
    import npu_pkg::*;

    localparam int ADDR_W = NPU_ADDR_W;
    localparam int DATA_W = NPU_DATA_W;
    localparam int CNT_W  = NPU_CNT_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  len = '0;
    logic              busy;
    logic              done;

    npu_in_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    npu_in_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM returns addr[7:0] one cycle after a request, noise otherwise.
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? bus.rd_addr[7:0] : 8'($urandom);
    end

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    int                exp_done_q[$];

    int errors = 0;
    int checks = 0;
    int issued = 0;
    int delivered = 0;
    int last_deliv = 0;
    int first_rd = -1;
    int first_valid = -1;
    int start_cyc = 0;
    bit prev_hold = 1'b0;
    bit prev_done = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (busy) begin
                chk("credit_bound", ((issued - delivered) <= 2) &&
                    !((issued - delivered) == 2 && bus.rd_en), 1);
                if (!enable) chk("enable_blocks_rd", bus.rd_en, 0);
            end
            if (bus.rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr_q.size() == 0) chk("unexpected_rd", exp_addr_q.size(), 1);
                else chk("rd_addr", bus.rd_addr, exp_addr_q.pop_front());
                issued++;
            end
            if (prev_hold) begin
                chk("hold_valid", bus.buf_valid, 1);
                chk("hold_data", bus.buf_data, prev_data);
            end
            if (bus.buf_valid && first_valid < 0) first_valid = cyc;
            if (bus.buf_valid && bus.buf_ready) begin
                if (exp_data_q.size() == 0) chk("unexpected_word", exp_data_q.size(), 1);
                else chk("buf_data", bus.buf_data, exp_data_q.pop_front());
                delivered++;
                last_deliv = cyc;
            end
            prev_hold = bus.buf_valid && !bus.buf_ready;
            prev_data = bus.buf_data;
            if (done) begin
                chk("done_width", prev_done, 0);
                chk("busy_at_done", busy, 1);
                chk("drained_at_done", exp_data_q.size(), 0);
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", exp_done_q.size(), 1);
                end else begin
                    int e;
                    e = exp_done_q.pop_front();
                    chk("done_cycle", cyc, (e < 0) ? last_deliv + 1 : e);
                end
            end
            prev_done = done;
        end else begin
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] b, input logic [15:0] n, input bit timed, input int extra);
        int s;
        s = cyc;
        for (int i = 0; i < int'(n); i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(a[7:0]);
        end
        if (!timed) exp_done_q.push_back(-1);
        else if (n == 0) exp_done_q.push_back(s + 1);
        else exp_done_q.push_back(s + int'(n) + 2 + extra);
        start_cyc   = s;
        first_rd    = -1;
        first_valid = -1;
        start       = 1'b1;
        base_addr   = b;
        len         = n;
        tick();
        start     = 1'b0;
        base_addr = 16'($urandom);
        len       = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int k;
        k = 0;
        while (exp_done_q.size() != 0 && k < budget) begin
            if (rand_ready) bus.buf_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        chk("done_timeout", exp_done_q.size(), 0);
        exp_done_q.delete();
        bus.buf_ready = 1'b1;
    endtask

    task automatic check_idle(input string name);
        chk(name, {bus.rd_en, bus.rd_addr, bus.buf_valid, bus.buf_data, busy, done}, '0);
    endtask

    initial begin
        bus.buf_ready = 1'b1;
        enable        = 1'b1;
        reset         = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset_outputs");
        tick();
        reset = 1'b1;
        tick();

        // Streaming with exact latency
        launch(16'h0010, 16'd4, 1'b1, 0);
        wait_done(50, 1'b0);
        chk("first_rd_latency", first_rd, start_cyc + 1);
        chk("first_valid_latency", first_valid, start_cyc + 2);

        // Address wrap and zero length
        launch(16'hFFFE, 16'd3, 1'b1, 0);
        wait_done(50, 1'b0);
        launch(16'h1234, 16'd0, 1'b1, 0);
        wait_done(50, 1'b0);

        // Backpressure after the second word
        begin
            int d0;
            int k;
            d0 = delivered;
            launch(16'h0040, 16'd6, 1'b0, 0);
            k = 0;
            while (delivered < d0 + 2 && k < 50) begin
                tick();
                k++;
            end
            bus.buf_ready = 1'b0;
            repeat (4) tick();
            chk("stall_buffered", issued - delivered, 2);
            bus.buf_ready = 1'b1;
            wait_done(100, 1'b0);
        end

        // Enable low for 3 cycles with a read in flight, buffer stalled meanwhile
        launch(16'h0100, 16'd4, 1'b1, 3);
        tick();
        enable        = 1'b0;
        bus.buf_ready = 1'b0;
        repeat (3) tick();
        enable        = 1'b1;
        bus.buf_ready = 1'b1;
        wait_done(50, 1'b0);

        // Start pulsed during DRAIN is ignored
        launch(16'h0200, 16'd3, 1'b1, 0);
        repeat (3) tick();
        start     = 1'b1;
        base_addr = 16'h5555;
        len       = 16'd7;
        tick();
        start = 1'b0;
        wait_done(50, 1'b0);
        launch(16'h0300, 16'd2, 1'b1, 0);
        wait_done(50, 1'b0);

        // Reset mid-RUN aborts the transfer
        launch(16'h0400, 16'd5, 1'b0, 0);
        tick();
        reset = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done_q.delete();
        issued    = 0;
        delivered = 0;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset_mid_run");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", {busy, done}, 0);
        launch(16'h0500, 16'd3, 1'b1, 0);
        wait_done(50, 1'b0);

        // Randomized transfers with random backpressure
        for (int t = 0; t < 10; t++) begin
            bus.buf_ready = ($urandom_range(0, 1) != 0);
            launch(16'($urandom), 16'($urandom_range(1, 8)), 1'b0, 0);
            wait_done(300, 1'b1);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1);
    end

endmodule
